// File: rtl/operand_stream_reader.sv
// Operand stream reader: walks an N x N row-major matrix held in the operand
// register file and presents it as a valid/ready element stream. The walk is
// row-major, or column-major when transposed. Read data returns one cycle
// after the address. A 2-entry FIFO absorbs consumer stalls.
module operand_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int MAX_DIM    = 4,
   parameter int DIM_WIDTH  = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [DIM_WIDTH-1:0]  dim_i,
   input  logic                  transpose_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  row_last_o,
   output logic                  last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   localparam logic [ADDR_WIDTH-1:0] PITCH     = ADDR_WIDTH'(MAX_DIM);
   localparam logic [DIM_WIDTH-1:0]  DIM_LIMIT = DIM_WIDTH'(MAX_DIM);

   state_t                 state_q, state_d;
   logic [DIM_WIDTH-1:0]   n_q, i_q, j_q, dim_clamped;
   logic                   transpose_q;
   logic                   issue, pop, push, done_d;
   logic                   j_wrap, last_elem;
   logic [2:0]             occ_after;
   logic [DIM_WIDTH-1:0]   row_sel, col_sel;

   // Return path: read issued in p0, data and tags land in p1
   logic                   vld_p1, row_last_p1, last_p1;

   // 2-entry elastic buffer
   logic [DATA_WIDTH-1:0]  fifo_data [2];
   logic                   fifo_rl   [2];
   logic                   fifo_last [2];
   logic                   wr_ptr_q, rd_ptr_q;
   logic [1:0]             count_q;
   logic                   done_q;

   assign dim_clamped = (dim_i > DIM_LIMIT) ? DIM_LIMIT : dim_i;
   assign j_wrap      = (j_q == n_q - DIM_WIDTH'(1));
   assign last_elem   = j_wrap && (i_q == n_q - DIM_WIDTH'(1));

   // Transposed walk swaps the roles of the counters in the address
   assign row_sel = transpose_q ? j_q : i_q;
   assign col_sel = transpose_q ? i_q : j_q;
   assign addr_o  = ADDR_WIDTH'(row_sel) * PITCH + ADDR_WIDTH'(col_sel);

   assign valid_o    = (count_q != 2'd0);
   assign pop        = valid_o & ready_i;
   assign push       = vld_p1;
   assign data_o     = valid_o ? fifo_data[rd_ptr_q] : '0;
   assign row_last_o = valid_o & fifo_rl[rd_ptr_q];
   assign last_o     = valid_o & fifo_last[rd_ptr_q];
   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = done_q;

   // Occupancy seen by the issue rule, crediting a pop happening this cycle
   assign occ_after = {1'b0, count_q} + {2'b00, vld_p1} - {2'b00, pop};

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state, issue and completion decode
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (dim_clamped == '0) done_d  = 1'b1;
               else                   state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue = (occ_after < 3'd2);
            if (issue && last_elem) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && fifo_last[rd_ptr_q]) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Walk counters and latched walk configuration
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_q         <= '0;
         transpose_q <= 1'b0;
         i_q         <= '0;
         j_q         <= '0;
      end else begin
         if (state_q == S_IDLE && start_i) begin
            n_q         <= dim_clamped;
            transpose_q <= transpose_i;
         end
         if (issue) begin
            if (j_wrap) begin
               j_q <= '0;
               i_q <= last_elem ? '0 : i_q + DIM_WIDTH'(1);
            end else begin
               j_q <= j_q + DIM_WIDTH'(1);
            end
         end
      end
   end

   // Stage p0 -> p1: tags travel alongside the outstanding read
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p1      <= 1'b0;
         row_last_p1 <= 1'b0;
         last_p1     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         vld_p1      <= issue;
         row_last_p1 <= issue & j_wrap;
         last_p1     <= issue & last_elem;
         done_q      <= done_d;
      end
   end

   // Buffer pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Stage p1 -> buffer: storage is not reset, outputs are gated by valid_o
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_data[wr_ptr_q] <= rd_data_i;
         fifo_rl[wr_ptr_q]   <= row_last_p1;
         fifo_last[wr_ptr_q] <= last_p1;
      end
   end

endmodule

// File: tb/tb_operand_stream_reader.sv
module tb_operand_stream_reader;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [2:0]  dim_i = '0;
   logic        transpose_i = 1'b0;
   logic [3:0]  addr_o;
   logic [31:0] rd_data_i = '0;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic        row_last_o;
   logic        last_o;
   logic        busy_o;
   logic        done_o;

   int n_checks = 0;
   int n_fail   = 0;
   int mem_base = 0;

   // Per-walk observations
   int acc_data[$];
   int acc_rl[$];
   int acc_last[$];
   int acc_k[$];
   int done_k, done_cnt, stall_err, max_occ, busy_k1, busy_done, valid_seen;

   operand_stream_reader #(
      .DATA_WIDTH(32), .ADDR_WIDTH(4), .MAX_DIM(4), .DIM_WIDTH(3)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .dim_i(dim_i),
      .transpose_i(transpose_i), .addr_o(addr_o), .rd_data_i(rd_data_i),
      .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .row_last_o(row_last_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // Operand register file model: registered read, mem[a] = mem_base + a
   always @(posedge clk_i) rd_data_i <= 32'(mem_base) + {28'd0, addr_o};

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Run one walk; k counts samples taken 1 time unit after each edge, k=0
   // being the edge that samples start_i
   task automatic do_walk(input int dim, input bit tr, input bit rand_rdy,
                          input int poke_k, input int budget);
      logic        prev_hold;
      logic [31:0] prev_data;
      acc_data.delete(); acc_rl.delete(); acc_last.delete(); acc_k.delete();
      done_k = -1; done_cnt = 0; stall_err = 0; max_occ = 0;
      busy_k1 = -1; busy_done = -1; valid_seen = 0;
      prev_hold = 1'b0; prev_data = '0;
      @(negedge clk_i);
      start_i = 1'b1; dim_i = 3'(dim); transpose_i = tr;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (k > 0) begin
            @(posedge clk_i); #1;
         end
         if (k == poke_k) begin
            start_i = 1'b1; dim_i = 3'd2; transpose_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (prev_hold && (!valid_o || data_o !== prev_data)) stall_err++;
         if (int'(dut.count_q) + int'(dut.vld_p1) > max_occ)
            max_occ = int'(dut.count_q) + int'(dut.vld_p1);
         if (k == 1) busy_k1 = int'(busy_o);
         if (valid_o) valid_seen++;
         if (done_o) begin
            done_cnt++;
            if (done_k < 0) begin
               done_k = k;
               busy_done = int'(busy_o);
            end
         end
         if (valid_o && ready_i) begin
            acc_data.push_back(int'(data_o));
            acc_rl.push_back(int'(row_last_o));
            acc_last.push_back(int'(last_o));
            acc_k.push_back(k);
         end
         prev_hold = valid_o && !ready_i;
         prev_data = data_o;
         if (done_k >= 0 && k >= done_k + 3) break;
      end
      start_i = 1'b0;
      ready_i = 1'b1;
      check_val("done_seen", (done_k >= 0), 1);
   endtask

   initial begin
      int exp2[9];
      int exp3[9];
      int no_done;
      exp2 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      exp3 = '{0, 4, 8, 1, 5, 9, 2, 6, 10};

      // Reset state
      #1;
      check_val("rst_valid", valid_o, 0);
      check_val("rst_busy", busy_o, 0);
      check_val("rst_done", done_o, 0);
      check_val("rst_addr", addr_o, 0);
      check_val("rst_data", data_o, 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_ni = 1'b1;

      // Test 1: reset in the middle of a walk
      mem_base = 0;
      @(negedge clk_i);
      start_i = 1'b1; dim_i = 3'd4; transpose_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (4) @(negedge clk_i);
      check_val("t1_busy_before", busy_o, 1);
      rst_ni = 1'b0;
      #1;
      check_val("t1_valid", valid_o, 0);
      check_val("t1_busy", busy_o, 0);
      check_val("t1_addr", addr_o, 0);
      check_val("t1_data", data_o, 0);
      check_val("t1_row_last", row_last_o, 0);
      check_val("t1_last", last_o, 0);
      @(negedge clk_i) rst_ni = 1'b1;
      no_done = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk_i); #1;
         if (done_o || valid_o || busy_o) no_done++;
      end
      check_val("t1_quiet_after", no_done, 0);
      check_val("t1_addr_after", addr_o, 0);

      // Test 2: N=3 row-major, ready held high
      mem_base = 0;
      do_walk(3, 1'b0, 1'b0, -1, 60);
      check_val("t2_count", acc_data.size(), 9);
      for (int e = 0; e < 9 && e < acc_data.size(); e++) begin
         check_val($sformatf("t2_data%0d", e), acc_data[e], exp2[e]);
         check_val($sformatf("t2_cycle%0d", e), acc_k[e], 2 + e);
         check_val($sformatf("t2_rl%0d", e), acc_rl[e], (e % 3 == 2) ? 1 : 0);
         check_val($sformatf("t2_last%0d", e), acc_last[e], (e == 8) ? 1 : 0);
      end
      check_val("t2_done_cycle", done_k, 11);
      check_val("t2_done_cnt", done_cnt, 1);
      check_val("t2_busy_k1", busy_k1, 1);
      check_val("t2_busy_at_done", busy_done, 0);

      // Test 3: N=3 transposed
      do_walk(3, 1'b1, 1'b0, -1, 60);
      check_val("t3_count", acc_data.size(), 9);
      for (int e = 0; e < 9 && e < acc_data.size(); e++) begin
         check_val($sformatf("t3_data%0d", e), acc_data[e], exp3[e]);
         check_val($sformatf("t3_rl%0d", e), acc_rl[e], (e % 3 == 2) ? 1 : 0);
         check_val($sformatf("t3_last%0d", e), acc_last[e], (e == 8) ? 1 : 0);
      end
      check_val("t3_done_cnt", done_cnt, 1);

      // Test 4: N=4 with random backpressure, row-major so data = base + index
      mem_base = 100;
      do_walk(4, 1'b0, 1'b1, -1, 400);
      check_val("t4_count", acc_data.size(), 16);
      for (int e = 0; e < 16 && e < acc_data.size(); e++) begin
         check_val($sformatf("t4_data%0d", e), acc_data[e], 100 + e);
         check_val($sformatf("t4_rl%0d", e), acc_rl[e], (e % 4 == 3) ? 1 : 0);
         check_val($sformatf("t4_last%0d", e), acc_last[e], (e == 15) ? 1 : 0);
      end
      check_val("t4_stall_stable", stall_err, 0);
      check_val("t4_occ_bound", (max_occ <= 2), 1);
      check_val("t4_done_cnt", done_cnt, 1);

      // Test 5: N=0 gives only a done pulse; oversize N clamps to 4
      do_walk(0, 1'b0, 1'b0, -1, 20);
      check_val("t5_zero_valid", valid_seen, 0);
      check_val("t5_zero_done_cycle", done_k, 0);
      check_val("t5_zero_busy", busy_done, 0);
      check_val("t5_zero_done_cnt", done_cnt, 1);
      mem_base = 0;
      do_walk(7, 1'b0, 1'b0, -1, 80);
      check_val("t5_clamp_count", acc_data.size(), 16);
      if (acc_data.size() == 16) begin
         check_val("t5_clamp_first", acc_data[0], 0);
         check_val("t5_clamp_mid", acc_data[5], 5);
         check_val("t5_clamp_lastdata", acc_data[15], 15);
         check_val("t5_clamp_lastflag", acc_last[15], 1);
      end
      check_val("t5_clamp_done_cycle", done_k, 18);

      // Test 6: start pulsed while busy is ignored
      do_walk(3, 1'b0, 1'b0, 4, 60);
      check_val("t6_count", acc_data.size(), 9);
      for (int e = 0; e < 9 && e < acc_data.size(); e++)
         check_val($sformatf("t6_data%0d", e), acc_data[e], exp2[e]);
      check_val("t6_done_cycle", done_k, 11);
      check_val("t6_done_cnt", done_cnt, 1);
      check_val("t6_idle_after", busy_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
